// File: rtl/pipeline.sv
// Three-stage 32-bit integer pipeline: IF/ID latch, decode with register read and
// EX-to-ID forwarding, then ALU execute with register-file writeback.
module pipeline (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] InstrIn,
    input  logic        WriteEnable,
    output logic [31:0] ALUOut
);

    function automatic logic [31:0] alu(
        input logic        [2:0]  fn,
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        logic [31:0] r;
        case (fn)
            3'd0:    r = a;
            3'd1:    r = ~a;
            3'd2:    r = a + b;
            3'd3:    r = a - b;
            3'd4:    r = a | b;
            3'd5:    r = a & b;
            3'd6:    r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic [31:0]        regs_q [32];
    logic [31:0]        regs_d [32];

    logic [31:0]        instr_p0_q, instr_p0_d;
    logic               we_p0_q, we_p0_d;

    logic signed [31:0] a_p1_q, a_p1_d;
    logic signed [31:0] b_p1_q, b_p1_d;
    logic [2:0]         func_p1_q, func_p1_d;
    logic [4:0]         rd_p1_q, rd_p1_d;
    logic               vld_p1_q, vld_p1_d;
    logic               wr_p1_q, wr_p1_d;

    logic [31:0]        alu_out_p2_q, alu_out_p2_d;

    logic [5:0]         op_p0;
    logic [4:0]         rd_p0, rs_p0, rt_p0;
    logic [15:0]        imm_p0;
    logic signed [31:0] rs_val_p0, rt_val_p0;
    logic [31:0]        ex_res_p1;

    always_comb begin
        // IF/ID capture
        instr_p0_d = InstrIn;
        we_p0_d    = WriteEnable;

        // EX result; a decoded NOP always yields zero
        ex_res_p1 = vld_p1_q ? alu(func_p1_q, a_p1_q, b_p1_q) : 32'd0;

        // ID: field decode, register read with forwarding from the writing EX instruction
        op_p0  = instr_p0_q[31:26];
        rd_p0  = instr_p0_q[25:21];
        rs_p0  = instr_p0_q[20:16];
        rt_p0  = instr_p0_q[15:11];
        imm_p0 = instr_p0_q[15:0];

        rs_val_p0 = (wr_p1_q && (rd_p1_q == rs_p0)) ? ex_res_p1 : regs_q[rs_p0];
        rt_val_p0 = (wr_p1_q && (rd_p1_q == rt_p0)) ? ex_res_p1 : regs_q[rt_p0];

        vld_p1_d  = (op_p0[5:4] == 2'b01);
        wr_p1_d   = vld_p1_d && we_p0_q;
        func_p1_d = op_p0[2:0];
        rd_p1_d   = rd_p0;
        a_p1_d    = rs_val_p0;
        b_p1_d    = (op_p0[5:3] == 3'b011) ? {16'd0, imm_p0} : rt_val_p0;

        // EX: result register and writeback
        alu_out_p2_d = ex_res_p1;
        regs_d = regs_q;
        if (wr_p1_q) begin
            regs_d[rd_p1_q] = ex_res_p1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_p0_q   <= '0;
            we_p0_q      <= 1'b0;
            a_p1_q       <= '0;
            b_p1_q       <= '0;
            func_p1_q    <= '0;
            rd_p1_q      <= '0;
            vld_p1_q     <= 1'b0;
            wr_p1_q      <= 1'b0;
            alu_out_p2_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            instr_p0_q   <= instr_p0_d;
            we_p0_q      <= we_p0_d;
            a_p1_q       <= a_p1_d;
            b_p1_q       <= b_p1_d;
            func_p1_q    <= func_p1_d;
            rd_p1_q      <= rd_p1_d;
            vld_p1_q     <= vld_p1_d;
            wr_p1_q      <= wr_p1_d;
            alu_out_p2_q <= alu_out_p2_d;
            regs_q       <= regs_d;
        end
    end

    assign ALUOut = alu_out_p2_q;

endmodule

// File: tb/tb_pipeline.sv
// Scoreboard bench for pipeline: directed instruction stream with hand-computed
// ALUOut values queued at issue time and checked by an independent monitor.
module tb_pipeline;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] InstrIn;
    logic        WriteEnable;
    logic [31:0] ALUOut;

    pipeline dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .InstrIn     (InstrIn),
        .WriteEnable (WriteEnable),
        .ALUOut      (ALUOut)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          due;
        logic [31:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        cyc    = 0;
    int        errors = 0;
    int        checks = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: ALUOut for an entry is valid between edge 'due' and the next edge
    sb_entry_t e;
    always @(negedge Clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.due < cyc) begin
                errors++;
                $display("FAIL %s: check missed at cycle %0d (due %0d), expected=%08h",
                         e.name, cyc, e.due, e.exp);
            end else if (ALUOut !== e.exp) begin
                errors++;
                $display("FAIL %s: ALUOut=%08h expected=%08h", e.name, ALUOut, e.exp);
            end
        end
    end

    function automatic logic [31:0] r_ins(input logic [2:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {3'b010, fn, rd, rs, rt, 11'd0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [2:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {3'b011, fn, rd, rs, imm};
    endfunction

    task automatic expect_at(input int due, input logic [31:0] exp, input string name);
        sb_entry_t n;
        n.due  = due;
        n.exp  = exp;
        n.name = name;
        sb.push_back(n);
    endtask

    // Called #1 after a rising edge; the instruction is sampled at the next edge
    task automatic drive(input logic [31:0] ins, input logic we);
        InstrIn     = ins;
        WriteEnable = we;
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic we,
                         input logic [31:0] exp, input string name);
        expect_at(cyc + 3, exp, name);
        drive(ins, we);
    endtask

    initial begin
        Reset       = 1'b1;
        InstrIn     = 32'h0;
        WriteEnable = 1'b1;
        repeat (10) begin
            @(posedge Clk);
            #1;
            expect_at(cyc, 32'h0, "reset_hold");
        end
        Reset = 1'b0;

        // All-zero instructions with write permission behave as NOPs
        repeat (3) issue(32'h0, 1'b1, 32'h0, "nop_zero");

        issue(i_ins(3'd2, 5'd0, 5'd0, 16'h0005), 1'b1, 32'h00000005, "addi_r0");
        issue(i_ins(3'd2, 5'd1, 5'd1, 16'h000A), 1'b1, 32'h0000000A, "addi_r1");
        issue(i_ins(3'd2, 5'd2, 5'd2, 16'hFFF8), 1'b1, 32'h0000FFF8, "addi_r2");
        issue(i_ins(3'd1, 5'd3, 5'd3, 16'h0000), 1'b1, 32'hFFFFFFFF, "noti_r3");
        issue(i_ins(3'd4, 5'd4, 5'd4, 16'hAAAA), 1'b1, 32'h0000AAAA, "ori_r4");
        issue(i_ins(3'd5, 5'd5, 5'd5, 16'hFFFF), 1'b1, 32'h00000000, "andi_r5");
        issue(i_ins(3'd6, 5'd6, 5'd6, 16'hFFF8), 1'b1, 32'h00000001, "slti_r6");

        issue(r_ins(3'd1, 5'd7,  5'd1, 5'd0), 1'b1, 32'hFFFFFFF5, "not_r7");
        issue(r_ins(3'd2, 5'd8,  5'd1, 5'd2), 1'b1, 32'h00010002, "add_r8");
        issue(r_ins(3'd2, 5'd9,  5'd1, 5'd3), 1'b1, 32'h00000009, "add_r9");
        issue(r_ins(3'd2, 5'd10, 5'd1, 5'd4), 1'b1, 32'h0000AAB4, "add_r10");
        issue(r_ins(3'd2, 5'd11, 5'd1, 5'd5), 1'b1, 32'h0000000A, "add_r11");
        issue(r_ins(3'd2, 5'd12, 5'd1, 5'd6), 1'b1, 32'h0000000B, "add_r12");

        // Signed compare with a negative operand, subtract, the zero function
        issue(r_ins(3'd6, 5'd21, 5'd7, 5'd1), 1'b1, 32'h00000001, "slt_neg");
        issue(r_ins(3'd3, 5'd22, 5'd1, 5'd2), 1'b1, 32'hFFFF0012, "sub_r22");
        issue(r_ins(3'd7, 5'd23, 5'd1, 5'd2), 1'b1, 32'h00000000, "zero_fn");
        // op[5:4]=11 is a NOP: no write to r1 and nothing forwarded
        issue({6'b110010, 5'd1, 5'd1, 5'd1, 11'd0}, 1'b1, 32'h00000000, "nop_op11");
        issue(r_ins(3'd0, 5'd25, 5'd1, 5'd0), 1'b1, 32'h0000000A, "nop_nowrite");
        // Forwarding into the rt operand
        issue(i_ins(3'd2, 5'd27, 5'd27, 16'h0003), 1'b1, 32'h00000003, "addi_r27");
        issue(r_ins(3'd2, 5'd28, 5'd1, 5'd27), 1'b1, 32'h0000000D, "fwd_rt");

        issue(i_ins(3'd2, 5'd13, 5'd13, 16'h0007), 1'b1, 32'h00000007, "addi_r13");
        issue(r_ins(3'd2, 5'd14, 5'd13, 5'd13), 1'b1, 32'h0000000E, "fwd_rs_rt");

        issue(i_ins(3'd2, 5'd15, 5'd15, 16'h0001), 1'b0, 32'h00000001, "addi_we0");
        issue(r_ins(3'd0, 5'd16, 5'd15, 5'd0), 1'b1, 32'h00000000, "pass_we0");
        issue(r_ins(3'd0, 5'd16, 5'd15, 5'd0), 1'b1, 32'h00000000, "reg_we0");

        // Mid-stream reset with two writers in flight
        drive(i_ins(3'd2, 5'd1, 5'd1, 16'h0003), 1'b1);
        drive(i_ins(3'd2, 5'd18, 5'd18, 16'h0004), 1'b1);
        Reset       = 1'b1;
        InstrIn     = 32'h0;
        WriteEnable = 1'b1;
        expect_at(cyc + 1, 32'h0, "rst_flush_a");
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        expect_at(cyc + 1, 32'h0, "rst_flush_b");
        issue(r_ins(3'd0, 5'd19, 5'd1, 5'd0), 1'b1, 32'h00000000, "rst_r1");
        issue(r_ins(3'd0, 5'd20, 5'd18, 5'd0), 1'b1, 32'h00000000, "rst_r18");
        issue(r_ins(3'd0, 5'd20, 5'd2, 5'd0), 1'b1, 32'h00000000, "rst_r2");
        issue(i_ins(3'd2, 5'd2, 5'd2, 16'h1234), 1'b1, 32'h00001234, "post_rst");

        for (int i = 0; i < 20 && sb.size() > 0; i++) drive(32'h0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: no output observed by cycle %0d, expected=%08h",
                     e.name, cyc, e.exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/pipeline.md
PIPELINE -- requirements
Module: pipeline

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits with 32 general-purpose registers.
REQ-002 Clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 Reset  input  1  reset, synchronous and active-high.
REQ-004 InstrIn  input  32  instruction presented each cycle, sampled on the rising edge.
REQ-005 WriteEnable  input  1  register-write permission, sampled with InstrIn and carried down the pipeline with that instruction.
REQ-006 ALUOut  output  32  registered ALU result of the instruction leaving EX.

Function
REQ-007 Instruction fields SHALL be op=[31:26], rd=[25:21], rs=[20:16], rt=[15:11], imm=[15:0]; imm SHALL be zero-extended to 32 bits.
REQ-008 op[5:3]=010 SHALL be R-type with operand B=R[rt]; op[5:3]=011 SHALL be I-type with operand B=zext(imm); operand A SHALL always be R[rs].
REQ-009 ALU function by op[2:0]:
- 000 pass A
- 001 NOT A
- 010 A+B, mod 2^32, no flags
- 011 A-B
- 100 A OR B
- 101 A AND B
- 110 SLT: 32'h1 if signed A<B, else 32'h0
- 111 result 0
REQ-010 Any op with op[5:4]!=01 SHALL be a NOP: result 0 and no register write; this includes InstrIn=32'h0.
REQ-011 Register r0 SHALL be an ordinary writable register (not hardwired to zero).
REQ-012 Pipeline stages SHALL be:
- IF/ID register capturing InstrIn and WriteEnable at edge N.
- ID: register read and immediate extend, captured into ID/EX at edge N+1.
- EX: ALU, result captured into ALUOut at edge N+2; R[rd] written at the same edge when the instruction is valid and its WriteEnable=1.
REQ-013 ALUOut SHALL show the result of an instruction sampled at edge N from edge N+2 until edge N+3; one instruction SHALL be accepted per cycle, with no stalls and no handshake.
REQ-014 If the instruction in EX writes register X, an ID-stage read of X in the same cycle SHALL return the EX result (forwarding), so back-to-back dependent instructions see the new value.
REQ-015 If a NOP or an instruction with WriteEnable=0 is in EX, no forwarding and no write SHALL occur; ALUOut still updates with its computed result (0 for a NOP).
REQ-016 rs and rt reading the same register, or rd equal to rs, SHALL be legal; the operand is the pre-instruction value (or the forwarded value per REQ-014).

Reset
REQ-017 While Reset=1 at a rising edge, all 32 registers, IF/ID, ID/EX and ALUOut SHALL clear to 0 and WriteEnable SHALL be ignored.
REQ-018 Reset asserted mid-stream SHALL discard all in-flight instructions; none of them may write a register after Reset is sampled high.
REQ-019 The first instruction sampled at the first edge with Reset=0 SHALL follow REQ-012 timing exactly.

Verification
REQ-020 Reset for 10 cycles, hold InstrIn=0 with WriteEnable=1 for 3 cycles -> ALUOut stays 0 and all registers stay 0.
REQ-021 I-type sequence, one per cycle -> ALUOut 2 cycles later shows:
- addi r0,r0,5 -> 00000005
- addi r1,r1,000A -> 0000000A
- addi r2,r2,FFF8 -> 0000FFF8
- noti r3 -> FFFFFFFF
- ori r4,r4,AAAA -> 0000AAAA
- andi r5,r5,FFFF -> 00000000
- slti r6,r6,FFF8 -> 00000001
REQ-022 Then R-type -> ALUOut shows:
- not r7,r1 -> FFFFFFF5
- add r8,r1,r2 -> 00010002
- add r9,r1,r3 -> 00000009
- add r10,r1,r4 -> 0000AAB4
- add r11,r1,r5 -> 0000000A
- add r12,r1,r6 -> 0000000B
REQ-023 Forwarding: addi r13,r13,7 immediately followed by add r14,r13,r13 -> ALUOut 00000007 then 0000000E.
REQ-024 WriteEnable=0 on addi r15,r15,1, then pass r16,r15 -> ALUOut 00000001 then 00000000.
REQ-025 Assert Reset for 1 cycle with 2 instructions in flight -> ALUOut=0 next cycle and their destination registers read back as 0.
